// File: rtl/pwm_capture_pkg.sv
// Shared register offsets, register layouts and state encoding for the PWM capture block.
package pwm_capture_pkg;

    localparam logic [2:0] OFF_CTRL = 3'd0;
    localparam logic [2:0] OFF_IFR  = 3'd1;
    localparam logic [2:0] OFF_IMSK = 3'd2;
    localparam logic [2:0] OFF_PERL = 3'd4;
    localparam logic [2:0] OFF_PERH = 3'd5;
    localparam logic [2:0] OFF_HIL  = 3'd6;
    localparam logic [2:0] OFF_HIH  = 3'd7;

    typedef struct packed {
        logic [2:0] cs;
        logic       pol;
        logic       en;
    } ctrl_struct;

    typedef struct packed {
        logic lost;
        logic ovf;
        logic capf;
    } ifr_struct;

    typedef enum logic [1:0] {IDLE, ARM, ACT, INACT} cap_state_e;

    // Prescale selects 6/7 behave like "stop".
    function automatic logic ctrl_stopped(input ctrl_struct c);
        return !c.en || (c.cs == 3'd0) || (c.cs > 3'd5);
    endfunction

    function automatic logic tick_of(input logic [2:0] cs, input logic [9:0] div);
        logic t;
        t = 1'b0;
        case (cs)
            3'd1:    t = 1'b1;
            3'd2:    t = (div[2:0] == 3'd0);
            3'd3:    t = (div[5:0] == 6'd0);
            3'd4:    t = (div[7:0] == 8'd0);
            3'd5:    t = (div == 10'd0);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pwm_capture_sync.sv
// Two-flop synchronizer on the raw waveform plus a history flop for edge detection.
module pwm_capture_sync (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2, prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~prev;
    assign fall  = ~s2 & prev;
endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and active-phase width in prescaled ticks,
// exposes them through an 8-bit register window and raises a handshaked interrupt.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter logic [7:0] ADDR_BASE = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       interrupt_request,
    input  logic       interrupt_executed,
    input  logic       status_reg_interrupt_enable
);
    ctrl_struct ctrl;
    ifr_struct  ifr, ifr_d;
    logic [2:0] imsk;
    logic [15:0] per, hi, per_cnt, hi_cnt, per_d, hi_d;
    logic [7:0] per_tmp, hi_tmp;
    logic [9:0] clkdiv;
    cap_state_e state, state_d;
    logic level, rise, fall, act_edge, inact_edge, tick, stop;
    logic cap, ovf_set, ack, irq_d;
    logic [7:0] off;
    logic hit, wr_ctrl, wr_ifr, wr_imsk, rd_perl, rd_hil;
    logic unused;

    pwm_capture_sync u_sync (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .level(level), .rise(rise), .fall(fall)
    );

    // An edge is "active" when the new level is the active level selected by pol.
    assign act_edge   = (rise | fall) &  (level ^ ctrl.pol);
    assign inact_edge = (rise | fall) & ~(level ^ ctrl.pol);
    assign tick       = tick_of(ctrl.cs, clkdiv);
    assign stop       = ctrl_stopped(ctrl);

    assign off     = addr - ADDR_BASE;
    assign hit     = (off[7:3] == 5'd0);
    assign wr_ctrl = write && hit && (off[2:0] == OFF_CTRL);
    assign wr_ifr  = write && hit && (off[2:0] == OFF_IFR);
    assign wr_imsk = write && hit && (off[2:0] == OFF_IMSK);
    assign rd_perl = read && hit && (off[2:0] == OFF_PERL);
    assign rd_hil  = read && hit && (off[2:0] == OFF_HIL);
    assign ack     = interrupt_request && interrupt_executed;
    assign unused  = ^wdata[7:5];

    always_comb begin
        state_d = state;
        per_d   = per_cnt;
        hi_d    = hi_cnt;
        cap     = 1'b0;
        ovf_set = 1'b0;
        case (state)
            IDLE: begin
                per_d   = '0;
                hi_d    = '0;
                state_d = stop ? IDLE : ARM;
            end
            ARM: begin
                per_d = '0;
                hi_d  = '0;
                if (act_edge) state_d = ACT;
            end
            ACT: begin
                if (tick && per_cnt == 16'hFFFF) begin
                    ovf_set = 1'b1;
                    state_d = ARM;
                    per_d   = '0;
                    hi_d    = '0;
                end else begin
                    per_d = per_cnt + 16'(tick);
                    hi_d  = hi_cnt + 16'(tick);
                    if (inact_edge) state_d = INACT;
                end
            end
            INACT: begin
                if (tick && per_cnt == 16'hFFFF) begin
                    ovf_set = 1'b1;
                    state_d = ARM;
                    per_d   = '0;
                    hi_d    = '0;
                end else if (act_edge) begin
                    cap     = 1'b1;
                    state_d = ACT;
                    per_d   = '0;
                    hi_d    = '0;
                end else begin
                    per_d = per_cnt + 16'(tick);
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop || wr_ctrl) begin
            state_d = IDLE;
            per_d   = '0;
            hi_d    = '0;
            cap     = 1'b0;
            ovf_set = 1'b0;
        end
        if (wr_ctrl && !ctrl_stopped(ctrl_struct'(wdata[4:0]))) state_d = ARM;
    end

    // Hardware flag sets are applied after any clear so they win a same-cycle race.
    always_comb begin
        ifr_d = ifr;
        if (ack) ifr_d = '0;
        if (wr_ifr) ifr_d = ifr_d & ~wdata[2:0];
        ifr_d.capf = ifr_d.capf | cap;
        ifr_d.lost = ifr_d.lost | (cap & ifr.capf);
        ifr_d.ovf  = ifr_d.ovf | ovf_set;
        irq_d = ((ifr & imsk) != 3'd0) && status_reg_interrupt_enable && !ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl              <= '0;
            ifr               <= '0;
            imsk              <= '0;
            per               <= '0;
            hi                <= '0;
            per_tmp           <= '0;
            hi_tmp            <= '0;
            clkdiv            <= '0;
            per_cnt           <= '0;
            hi_cnt            <= '0;
            state             <= IDLE;
            interrupt_request <= 1'b0;
        end else begin
            clkdiv            <= clkdiv + 10'd1;
            state             <= state_d;
            per_cnt           <= per_d;
            hi_cnt            <= hi_d;
            ifr               <= ifr_d;
            interrupt_request <= irq_d;
            if (wr_ctrl) ctrl <= ctrl_struct'(wdata[4:0]);
            if (wr_imsk) imsk <= wdata[2:0];
            if (cap) begin
                per <= per_cnt + 16'(tick);
                hi  <= hi_cnt;
            end
            if (rd_perl) per_tmp <= per[15:8];
            if (rd_hil)  hi_tmp  <= hi[15:8];
        end
    end

    always_comb begin
        rdata = '0;
        if (read && hit) begin
            case (off[2:0])
                OFF_CTRL: rdata = {3'b0, ctrl};
                OFF_IFR:  rdata = {5'b0, ifr};
                OFF_IMSK: rdata = {5'b0, imsk};
                OFF_PERL: rdata = per[7:0];
                OFF_PERH: rdata = per_tmp;
                OFF_HIL:  rdata = hi[7:0];
                OFF_HIH:  rdata = hi_tmp;
                default:  rdata = '0;
            endcase
        end
    end
endmodule
